// File: rtl/btb_resolve_ctrl.sv
// btb_resolve_ctrl: in-order tracking of fetched predictions, resolution
// against EX outcomes, redirect/flush/history-restore on mispredict, and a
// single registered BTB/PHT training strobe per resolved control instruction.
module btb_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int GHR_BITS     = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_valid,
  input  logic [31:0]               fetch_pc,
  input  logic [31:0]               fetch_pred_pc,
  input  logic [GHR_BITS-1:0]       fetch_ghr,
  output logic                      fetch_ready,
  input  logic                      res_valid,
  input  logic                      res_is_ctrl,
  input  logic                      res_taken,
  input  logic [31:0]               res_target,
  output logic                      redirect_valid,
  output logic [31:0]               redirect_pc,
  output logic                      flush,
  output logic                      ghr_restore_valid,
  output logic [GHR_BITS-1:0]       ghr_restore_value,
  output logic                      upd_valid,
  output logic [31:0]               upd_pc,
  output logic [GHR_BITS-1:0]       upd_ghr,
  output logic                      upd_taken,
  output logic [31:0]               upd_target,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [31:0]               ctrl_cnt,
  output logic [31:0]               mispredict_cnt,
  output logic                      underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic [31:0]         q_pc   [DEPTH];
  logic [31:0]         q_pred [DEPTH];
  logic [GHR_BITS-1:0] q_ghr  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;

  logic                do_push, do_pop, mispredict, underflow_hit, actual_taken;
  logic [31:0]         head_pc, head_pred, actual_next;
  logic [GHR_BITS-1:0] head_ghr;

  assign head_pc   = q_pc[rd_ptr];
  assign head_pred = q_pred[rd_ptr];
  assign head_ghr  = q_ghr[rd_ptr];

  // Decode push/resolve/mispredict for the current cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    do_push       = 1'b0;
    do_pop        = 1'b0;
    mispredict    = 1'b0;
    underflow_hit = 1'b0;
    actual_taken  = res_is_ctrl & res_taken;
    actual_next   = actual_taken ? res_target : head_pc + 32'd4;
    if (state_q == RUN) begin
      do_push       = fetch_valid && (occupancy < FULL_OCC);
      do_pop        = res_valid && (occupancy != '0);
      underflow_hit = res_valid && (occupancy == '0);
      mispredict    = do_pop && (actual_next != head_pred);
    end
  end

  // FSM state register: RUN/FLUSH plus remaining flush cycles.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // FSM next state: a mispredict opens a FLUSH window of FLUSH_CYCLES cycles.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d     = FLUSH;
          flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) state_d = RUN;
        else                   flush_cnt_d = flush_cnt_q - CNT_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  // FSM outputs: flush follows the FLUSH state, fetch is gated by state and fullness.
  always_comb begin
    flush       = (state_q == FLUSH);
    fetch_ready = (state_q == RUN) && (occupancy < FULL_OCC);
  end

  // Queue storage: written on push only; validity is tracked by occupancy.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately not reset; stale entries are never read.
    if (do_push) begin
      q_pc[wr_ptr]   <= fetch_pc;
      q_pred[wr_ptr] <= fetch_pred_pc;
      q_ghr[wr_ptr]  <= fetch_ghr;
    end
  end

  // Queue pointers and occupancy; a mispredict clears the queue and drops any push.
  always_ff @(posedge clk) begin
    if (reset || mispredict) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      occupancy <= occupancy + OCC_W'(1);
      else if (!do_push && do_pop) occupancy <= occupancy - OCC_W'(1);
    end
  end

  // Registered resolve results: one-cycle pulses, training payload, statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      ghr_restore_valid <= 1'b0;
      ghr_restore_value <= '0;
      upd_valid         <= 1'b0;
      upd_pc            <= '0;
      upd_ghr           <= '0;
      upd_taken         <= 1'b0;
      upd_target        <= '0;
      ctrl_cnt          <= '0;
      mispredict_cnt    <= '0;
      underflow_err     <= 1'b0;
    end else begin
      redirect_valid    <= mispredict;
      ghr_restore_valid <= mispredict;
      upd_valid         <= do_pop && res_is_ctrl;
      if (mispredict) begin
        redirect_pc       <= actual_next;
        ghr_restore_value <= {head_ghr[GHR_BITS-2:0], actual_taken};
        if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 32'd1;
      end
      if (do_pop && res_is_ctrl) begin
        upd_pc     <= head_pc;
        upd_ghr    <= head_ghr;
        upd_taken  <= res_taken;
        upd_target <= res_target;
        if (ctrl_cnt != '1) ctrl_cnt <= ctrl_cnt + 32'd1;
      end
      if (underflow_hit) underflow_err <= 1'b1;
    end
  end

endmodule
